// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM port arbiter: grant encoding, FSM states
// and the fixed-priority winner selection used in IDLE.
package sdram_arb_pkg;

    // Grant encoding: which requester owns the outstanding command.
    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_A    = 2'd1;
    localparam logic [1:0] GNT_B    = 2'd2;
    localparam logic [1:0] GNT_REF  = 2'd3;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    // Priority: urgent refresh, forced B (fairness), A, B, pending refresh.
    function automatic logic [1:0] pick_winner(
        input logic ref_urgent,
        input logic force_b,
        input logic a_req,
        input logic b_req,
        input logic ref_due
    );
        logic [1:0] win;
        win = GNT_NONE;
        if (ref_urgent)            win = GNT_REF;
        else if (force_b && b_req) win = GNT_B;
        else if (a_req)            win = GNT_A;
        else if (b_req)            win = GNT_B;
        else if (ref_due)          win = GNT_REF;
        return win;
    endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Refresh interval counter plus saturating count of refreshes owed to the
// SDRAM. ref_due when any refresh is owed, ref_urgent when REF_MAX are owed.
module sdram_refresh_timer #(
    parameter int REFRESH_INT = 780,
    parameter int REF_MAX     = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ref_done,
    output logic ref_due,
    output logic ref_urgent
);
    import sdram_arb_pkg::*;

    localparam int CNT_W  = $clog2(REFRESH_INT);
    localparam int PEND_W = $clog2(REF_MAX + 1);

    logic [CNT_W-1:0]  interval_cnt;
    logic [PEND_W-1:0] ref_pending;
    logic              wrap;

    assign wrap       = (interval_cnt == CNT_W'(REFRESH_INT - 1));
    assign ref_due    = (ref_pending != '0);
    assign ref_urgent = (ref_pending == PEND_W'(REF_MAX));

    // Interval counter and owed-refresh bookkeeping; wrap plus completion cancel out.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            interval_cnt <= '0;
            ref_pending  <= '0;
        end else begin
            interval_cnt <= wrap ? '0 : interval_cnt + 1'b1;
            if (wrap && !ref_done) begin
                if (!ref_urgent)
                    ref_pending <= ref_pending + 1'b1;
            end else if (ref_done && !wrap) begin
                if (ref_due)
                    ref_pending <= ref_pending - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares the SDRAM controller command port between port A (cartridge ROM
// reads, latency-critical), port B (REU DMA) and the refresh scheduler.
// One command outstanding at a time; all outputs are registered.
// Optional: define SDRAM_ARB_FAIR_EN to force a B grant after FAIR_LIMIT
// consecutive A grants while B waits; otherwise strict priority.
module sdram_port_arbiter #(
    parameter int ADDR_W      = 25,
    parameter int REFRESH_INT = 780,
    parameter int REF_MAX     = 4
`ifdef SDRAM_ARB_FAIR_EN
    ,
    parameter int FAIR_LIMIT  = 8
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [7:0]        a_wdata,
    output logic              a_ack,
    output logic              a_rvalid,
    output logic [7:0]        a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [7:0]        b_wdata,
    output logic              b_ack,
    output logic              b_rvalid,
    output logic [7:0]        b_rdata,
    output logic              mem_req,
    output logic              mem_refresh,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic              mem_done,
    input  logic [7:0]        mem_rdata
);
    import sdram_arb_pkg::*;

    arb_state_t state, state_next;
    logic [1:0] gnt;
    logic [1:0] win;
    logic       finish;
    logic       ref_done;
    logic       ref_due;
    logic       ref_urgent;
    logic       force_b;

    sdram_refresh_timer #(
        .REFRESH_INT (REFRESH_INT),
        .REF_MAX     (REF_MAX)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .ref_done   (ref_done),
        .ref_due    (ref_due),
        .ref_urgent (ref_urgent)
    );

    // The command completes on mem_done in WAIT, or in ISSUE when ack and done coincide.
    assign finish   = mem_done && ((state == ST_WAIT) || (state == ST_ISSUE && mem_ack));
    assign ref_done = finish && (gnt == GNT_REF);

`ifdef SDRAM_ARB_FAIR_EN
    localparam int FAIR_W = $clog2(FAIR_LIMIT + 1);
    logic [FAIR_W-1:0] fair_cnt;

    assign force_b = (fair_cnt == FAIR_W'(FAIR_LIMIT));

    // Count consecutive A grants made while B waits; any B grant or idle B clears it.
    always_ff @(posedge clk) begin
        if (!reset_n)
            fair_cnt <= '0;
        else if (!b_req || win == GNT_B)
            fair_cnt <= '0;
        else if (win == GNT_A)
            fair_cnt <= fair_cnt + 1'b1;
    end
`else
    assign force_b = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Next-state and arbitration decision.
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        win        = GNT_NONE;
        unique case (state)
            ST_IDLE: begin
                win = pick_winner(ref_urgent, force_b, a_req, b_req, ref_due);
                if (win != GNT_NONE)
                    state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (mem_ack)
                    state_next = mem_done ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_done)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Command latch, ack/rvalid pulses and read data return.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            gnt         <= GNT_NONE;
            mem_req     <= 1'b0;
            mem_refresh <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            a_ack       <= 1'b0;
            b_ack       <= 1'b0;
            a_rvalid    <= 1'b0;
            b_rvalid    <= 1'b0;
            a_rdata     <= '0;
            b_rdata     <= '0;
        end else begin
            a_ack    <= 1'b0;
            b_ack    <= 1'b0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;

            if (win != GNT_NONE) begin
                gnt         <= win;
                mem_req     <= 1'b1;
                mem_refresh <= (win == GNT_REF);
                unique case (win)
                    GNT_A: begin
                        mem_we    <= a_we;
                        mem_addr  <= a_addr;
                        mem_wdata <= a_wdata;
                    end
                    GNT_B: begin
                        mem_we    <= b_we;
                        mem_addr  <= b_addr;
                        mem_wdata <= b_wdata;
                    end
                    default: begin
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                    end
                endcase
            end

            if (state == ST_ISSUE && mem_ack) begin
                mem_req <= 1'b0;
                a_ack   <= (gnt == GNT_A);
                b_ack   <= (gnt == GNT_B);
            end

            if (finish && !mem_we) begin
                if (gnt == GNT_A) begin
                    a_rdata  <= mem_rdata;
                    a_rvalid <= 1'b1;
                end
                if (gnt == GNT_B) begin
                    b_rdata  <= mem_rdata;
                    b_rvalid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed testbench for sdram_port_arbiter. The initial block plays both
// requesters and the SDRAM controller; a negedge monitor counts pulses.
module tb_sdram_port_arbiter;

    localparam int ADDR_W      = 25;
    localparam int REFRESH_INT = 780;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              a_req, a_we, b_req, b_we;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [7:0]        a_wdata, b_wdata;
    logic              a_ack, a_rvalid, b_ack, b_rvalid;
    logic [7:0]        a_rdata, b_rdata;
    logic              mem_req, mem_refresh, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ack, mem_done;
    logic [7:0]        mem_rdata;

    always #5 clk = ~clk;

    sdram_port_arbiter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .a_req       (a_req),
        .a_we        (a_we),
        .a_addr      (a_addr),
        .a_wdata     (a_wdata),
        .a_ack       (a_ack),
        .a_rvalid    (a_rvalid),
        .a_rdata     (a_rdata),
        .b_req       (b_req),
        .b_we        (b_we),
        .b_addr      (b_addr),
        .b_wdata     (b_wdata),
        .b_ack       (b_ack),
        .b_rvalid    (b_rvalid),
        .b_rdata     (b_rdata),
        .mem_req     (mem_req),
        .mem_refresh (mem_refresh),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_done    (mem_done),
        .mem_rdata   (mem_rdata)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Pulse monitor
    int         a_ack_cnt = 0, b_ack_cnt = 0, a_rv_cnt = 0, b_rv_cnt = 0, dual_ack = 0;
    logic [7:0] a_rd_last = '0, b_rd_last = '0;

    always @(negedge clk) begin
        if (a_ack === 1'b1) a_ack_cnt++;
        if (b_ack === 1'b1) b_ack_cnt++;
        if (a_ack === 1'b1 && b_ack === 1'b1) dual_ack++;
        if (a_rvalid === 1'b1) begin a_rv_cnt++; a_rd_last = a_rdata; end
        if (b_rvalid === 1'b1) begin b_rv_cnt++; b_rd_last = b_rdata; end
    end

    // Snapshot of monitor counters and per-transaction observations
    int                a0, b0, ar0, br0, d0;
    bit                a_hold, b_hold;
    bit                s_ok, s_refr, s_we, s_stable, s_ack_a, s_ack_b, s_req_after;
    logic [ADDR_W-1:0] s_addr;
    logic [7:0]        s_wdata;
    int                first_b;
    bit                seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic snap();
        a0 = a_ack_cnt; b0 = b_ack_cnt; ar0 = a_rv_cnt; br0 = b_rv_cnt; d0 = dual_ack;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        mem_ack = 1'b0; mem_done = 1'b0; mem_rdata = '0;
        a_hold = 1'b0; b_hold = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_mem_req(input int limit, output bit ok);
        int n = 0;
        while (mem_req !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        ok = (mem_req === 1'b1);
    endtask

    // Controller model for one command: ack ack_dly cycles after mem_req is
    // seen, done done_dly cycles after (same cycle when done_dly <= ack_dly).
    task automatic serve(input int ack_dly, input int done_dly, input logic [7:0] rd);
        bit ok;
        s_ok = 1'b0;
        wait_mem_req(200, ok);
        if (!ok) return;
        s_refr  = mem_refresh;
        s_we    = mem_we;
        s_addr  = mem_addr;
        s_wdata = mem_wdata;
        repeat (ack_dly) @(negedge clk);
        s_stable = (mem_req === 1'b1) && (mem_addr === s_addr) && (mem_we === s_we) &&
                   (mem_wdata === s_wdata) && (mem_refresh === s_refr);
        mem_ack = 1'b1;
        if (done_dly <= ack_dly) begin
            mem_done  = 1'b1;
            mem_rdata = rd;
        end
        @(negedge clk);
        mem_ack     = 1'b0;
        mem_done    = 1'b0;
        s_ack_a     = a_ack;
        s_ack_b     = b_ack;
        s_req_after = mem_req;
        if (a_ack === 1'b1 && !a_hold) a_req = 1'b0;
        if (b_ack === 1'b1 && !b_hold) b_req = 1'b0;
        if (done_dly > ack_dly) begin
            repeat (done_dly - ack_dly - 1) @(negedge clk);
            mem_done  = 1'b1;
            mem_rdata = rd;
            @(negedge clk);
            mem_done = 1'b0;
        end
        s_ok = 1'b1;
    endtask

    initial begin
        // ---- Reset state ----
        do_reset();
        settle(0);
        check("rst_mem_req",   32'(mem_req), 0);
        check("rst_mem_refr",  32'(mem_refresh), 0);
        check("rst_mem_we",    32'(mem_we), 0);
        check("rst_mem_addr",  32'(mem_addr), 0);
        check("rst_mem_wdata", 32'(mem_wdata), 0);
        check("rst_acks",      32'({a_ack, b_ack, a_rvalid, b_rvalid}), 0);
        check("rst_rdata",     32'({a_rdata, b_rdata}), 0);
        check("rst_pending",   32'(dut.u_timer.ref_pending), 0);

        // ---- 1: port A read, ack after 3, done after 6 ----
        snap();
        a_req = 1'b1; a_we = 1'b0; a_addr = 25'h0001234;
        serve(3, 6, 8'h5A);
        check("t1_ok",      32'(s_ok), 1);
        check("t1_addr",    32'(s_addr), 32'h0001234);
        check("t1_we",      32'(s_we), 0);
        check("t1_refresh", 32'(s_refr), 0);
        check("t1_stable",  32'(s_stable), 1);
        check("t1_ack_pls", 32'({s_ack_a, s_ack_b}), 32'b10);
        check("t1_req_off", 32'(s_req_after), 0);
        settle(3);
        check("t1_a_acks",  32'(a_ack_cnt - a0), 1);
        check("t1_a_rv",    32'(a_rv_cnt - ar0), 1);
        check("t1_a_rdata", 32'(a_rd_last), 32'h5A);
        check("t1_b_quiet", 32'((b_ack_cnt - b0) + (b_rv_cnt - br0)), 0);
        check("t1_idle",    32'(mem_req), 0);

        // ---- 2: A and B rise together, A first then B ----
        do_reset();
        snap();
        a_req = 1'b1; a_we = 1'b0; a_addr = 25'h0000AAA;
        b_req = 1'b1; b_we = 1'b0; b_addr = 25'h0000BBB;
        serve(1, 3, 8'h21);
        check("t2_first_a",  32'(s_addr), 32'h0000AAA);
        serve(2, 4, 8'h42);
        check("t2_second_b", 32'(s_addr), 32'h0000BBB);
        settle(3);
        check("t2_a_acks",   32'(a_ack_cnt - a0), 1);
        check("t2_b_acks",   32'(b_ack_cnt - b0), 1);
        check("t2_no_dual",  32'(dual_ack - d0), 0);
        check("t2_b_rdata",  32'(b_rd_last), 32'h42);

        // ---- 3: refresh backlog becomes urgent, beats A ----
        do_reset();
        a_hold = 1'b1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 25'h0000100;
        serve(4 * REFRESH_INT + 10, 4 * REFRESH_INT + 12, 8'h11);
        check("t3_stall_a",    32'({s_ok, s_refr}), 32'b10);
        settle(0);
        check("t3_pending4",   32'(dut.u_timer.ref_pending), 4);
        serve(2, 4, 8'h00);
        check("t3_urgent_ref", 32'({s_ok, s_refr}), 32'b11);
        settle(0);
        check("t3_pending3",   32'(dut.u_timer.ref_pending), 3);
        serve(1, 2, 8'h12);
        check("t3_a_next",     32'({s_ok, s_refr}), 32'b10);
        a_hold = 1'b0;
        serve(1, 2, 8'h13);
        check("t3_a_again",    32'({s_ok, s_refr}), 32'b10);
        for (int i = 0; i < 3; i++) begin
            serve(1, 3, 8'h00);
            check("t3_ref_drain", 32'({s_ok, s_refr}), 32'b11);
        end
        settle(20);
        check("t3_pending0",   32'(dut.u_timer.ref_pending), 0);
        check("t3_quiet",      32'(mem_req), 0);

        // ---- 4: B write at top address; then A with ack+done together ----
        do_reset();
        snap();
        b_req = 1'b1; b_we = 1'b1; b_addr = 25'h1FFFFFF; b_wdata = 8'hC3;
        serve(2, 4, 8'hEE);
        check("t4_addr",   32'(s_addr), 32'h1FFFFFF);
        check("t4_we",     32'(s_we), 1);
        check("t4_wdata",  32'(s_wdata), 32'hC3);
        check("t4_ack",    32'({s_ack_a, s_ack_b}), 32'b01);
        settle(3);
        check("t4_b_acks", 32'(b_ack_cnt - b0), 1);
        check("t4_no_rv",  32'(b_rv_cnt - br0), 0);
        snap();
        a_req = 1'b1; a_we = 1'b0; a_addr = 25'h00ABCDE;
        serve(2, 2, 8'h77);
        check("t4_same_ack",  32'(s_ack_a), 1);
        check("t4_same_idle", 32'(s_req_after), 0);
        settle(2);
        check("t4_same_rv",   32'(a_rv_cnt - ar0), 1);
        check("t4_same_data", 32'(a_rd_last), 32'h77);
        b_req = 1'b1; b_we = 1'b0; b_addr = 25'h0000777;
        serve(1, 3, 8'h3C);
        settle(2);
        check("t4_after_ok",  32'(s_ok), 1);
        check("t4_after_rd",  32'(b_rd_last), 32'h3C);

        // ---- 5: A continuous, B waiting ----
        do_reset();
        a_hold = 1'b1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 25'h000AAAA;
        b_req = 1'b1; b_we = 1'b0; b_addr = 25'h000BBBB;
        first_b = 0;
        for (int i = 1; i <= 100 && first_b == 0; i++) begin
            serve(1, 2, 8'h55);
            if (!s_ok) break;
            if (!s_refr && s_addr == 25'h000BBBB) first_b = i;
        end
        check("t5_ok", 32'(s_ok), 1);
`ifdef SDRAM_ARB_FAIR_EN
        check("t5_fair_b_after_8", 32'(first_b), 9);
`else
        check("t5_strict_b_starved", 32'(first_b), 0);
`endif

        // ---- 6: reset in WAIT, then reset in ISSUE ----
        do_reset();
        a_req = 1'b1; a_we = 1'b0; a_addr = 25'h0000042;
        wait_mem_req(50, seen);
        check("t6_req_seen", 32'(seen), 1);
        repeat (REFRESH_INT + 20) @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        a_req   = 1'b0;
        check("t6_pending1", 32'(dut.u_timer.ref_pending), 1);
        check("t6_ack_seen", 32'(a_ack), 1);
        reset_n = 1'b0;
        @(negedge clk);
        check("t6_req_off",  32'(mem_req), 0);
        check("t6_outs_off", 32'({a_ack, b_ack, a_rvalid, b_rvalid}), 0);
        check("t6_pending0", 32'(dut.u_timer.ref_pending), 0);
        reset_n = 1'b1;
        a_req = 1'b1;
        wait_mem_req(50, seen);
        check("t6_issue_seen", 32'(seen), 1);
        reset_n = 1'b0;
        a_req   = 1'b0;
        @(negedge clk);
        check("t6_issue_rst", 32'(mem_req), 0);
        reset_n = 1'b1;
        settle(10);
        check("t6_quiet", 32'(mem_req), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
